uart_rx: RTL and testbench

Oversampling UART receiver, the receive-side counterpart of the UART TX path in the UART subsystem. It recovers an 8-bit frame from the serial line RX_IN: start bit, data bits LSB first, optional parity, one stop bit. Each bit is sampled by 3-point majority vote at mid-bit on a clock running at Prescale × baud rate. Outputs are the parallel byte, a one-cycle valid strobe, and parity and stop error strobes, all toward the system controller through the RX clock-domain data synchronizer.

---
 rtl/uart_pkg.sv | 40 ++++
 rtl/uart_rx_sampler.sv | 61 ++++++
 rtl/uart_rx.sv | 191 +++++++++++++++++++
 tb/tb_uart_rx.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART subsystem (RX and TX paths).
//   - RX FSM state encoding (3-bit) and its enum type
//   - Line-level constants for the start and stop bits
//   - Legal oversampling ratios
//   - 3-input majority helper used by the RX sampler
// -----------------------------------------------------------------------------
package uart_pkg;

  // RX FSM state encoding
  localparam logic [2:0] RX_IDLE   = 3'd0;
  localparam logic [2:0] RX_START  = 3'd1;
  localparam logic [2:0] RX_DATA   = 3'd2;
  localparam logic [2:0] RX_PARITY = 3'd3;
  localparam logic [2:0] RX_STOP   = 3'd4;

  typedef enum logic [2:0] {
    IDLE   = RX_IDLE,
    START  = RX_START,
    DATA   = RX_DATA,
    PARITY = RX_PARITY,
    STOP   = RX_STOP
  } rx_state_t;

  // Line levels of the framing bits, shared with the TX path
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  // Legal oversampling ratios (Prescale values)
  localparam int PRESCALE_8  = 8;
  localparam int PRESCALE_16 = 16;
  localparam int PRESCALE_32 = 32;

  // Majority of three samples
  function automatic logic majority3(input logic [2:0] s);
    return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// -----------------------------------------------------------------------------
// uart_rx_sampler
// Captures the synchronized serial line at three points around mid-bit
// (edge_cnt = Prescale/2-1, Prescale/2, Prescale/2+1) and reports the
// majority of the three as the bit value.
// Ports:
//   clk, rst     clock / asynchronous active-low reset
//   rx_s         synchronized serial line
//   edge_cnt     position within the current bit (0..Prescale-1)
//   Prescale     oversampling ratio
//   sampled_bit  majority vote of the three captured samples
//   sample_done  high once all three samples of this bit are captured
//                (edge_cnt >= Prescale/2+2)
// -----------------------------------------------------------------------------
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int PRESCALE_W = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_s,
  input  logic [PRESCALE_W-1:0] edge_cnt,
  input  logic [PRESCALE_W-1:0] Prescale,
  output logic                  sampled_bit,
  output logic                  sample_done
);

  logic [PRESCALE_W-1:0] half;
  logic [2:0]            samples;

  assign half = Prescale >> 1;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_sample
      logic [PRESCALE_W-1:0] point;
      logic                  sample;

      // Sample points sit at half-1, half, half+1
      assign point = half + PRESCALE_W'(gi) - PRESCALE_W'(1);

      // Idle-high reset value keeps the vote at 1 before the first capture
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          sample <= 1'b1;
        end else if (edge_cnt == point) begin
          sample <= rx_s;
        end
      end

      assign samples[gi] = sample;
    end
  endgenerate

  assign sampled_bit = majority3(samples);
  // The last capture lands on the edge that ends edge_cnt = half+1, so
  // the vote reflects the current bit from half+2 onwards.
  assign sample_done = (edge_cnt >= (half + PRESCALE_W'(2)));

endmodule

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
// Oversampling UART receiver: start bit, DATA_WIDTH data bits LSB first,
// optional parity bit, one stop bit. Each bit is decided by a 3-point
// majority vote around mid-bit on a clock running at Prescale x baud.
// Ports:
//   clk         oversampling clock
//   rst         asynchronous active-low reset
//   RX_IN       serial line (idle high, asynchronous to clk)
//   Prescale    oversampling ratio (8, 16 or 32), static during a frame
//   PAR_EN      1 = parity bit present (latched at the end of the start bit)
//   PAR_TYP     0 = even, 1 = odd (latched at the end of the start bit)
//   P_DATA      received word, updated only on a good frame
//   data_valid  one-cycle strobe, frame good
//   Par_err     one-cycle strobe, parity mismatch
//   Stp_err     one-cycle strobe, stop bit sampled 0
// All three strobes come out together in the cycle after the stop bit's
// last oversampling edge; the FSM is already back in IDLE in that cycle.
// -----------------------------------------------------------------------------
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE_W = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  RX_IN,
  input  logic [PRESCALE_W-1:0] Prescale,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  data_valid,
  output logic                  Par_err,
  output logic                  Stp_err
);

  localparam int               BIT_W    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_WIDTH - 1);

  // ---------------------------------------------------------------------------
  // Two-flop synchronizer, reset to the idle line level
  // ---------------------------------------------------------------------------
  logic rx_meta;
  logic rx_s;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= RX_IN;
      rx_s    <= rx_meta;
    end
  end

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  rx_state_t             state;
  logic [PRESCALE_W-1:0] edge_cnt;
  logic [BIT_W-1:0]      bit_cnt;
  logic [DATA_WIDTH-1:0] shift_data;
  logic                  par_en_hold;
  logic                  par_typ_hold;
  logic                  par_fail;
  logic                  stp_fail;

  logic sampled_bit;
  logic sample_done;
  logic bit_end;
  logic parity_bad;
  logic stop_bad;
  logic stp_final;

  uart_rx_sampler #(
    .PRESCALE_W (PRESCALE_W)
  ) u_sampler (
    .clk         (clk),
    .rst         (rst),
    .rx_s        (rx_s),
    .edge_cnt    (edge_cnt),
    .Prescale    (Prescale),
    .sampled_bit (sampled_bit),
    .sample_done (sample_done)
  );

  // ">=" rather than "==" so an out-of-range Prescale can never strand the
  // counter past its terminal value.
  assign bit_end    = (edge_cnt >= (Prescale - PRESCALE_W'(1)));

  // In PARITY the shifter holds the complete data word.
  assign parity_bad = sample_done && (sampled_bit != ((^shift_data) ^ par_typ_hold));
  assign stop_bad   = sample_done && (sampled_bit != STOP_BIT);

  // Folds in a stop failure detected on the very last edge as well
  assign stp_final  = stp_fail | stop_bad;

  // ---------------------------------------------------------------------------
  // FSM, counters, shifter, checks and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      edge_cnt     <= '0;
      bit_cnt      <= '0;
      shift_data   <= '0;
      par_en_hold  <= 1'b0;
      par_typ_hold <= 1'b0;
      par_fail     <= 1'b0;
      stp_fail     <= 1'b0;
      P_DATA       <= '0;
      data_valid   <= 1'b0;
      Par_err      <= 1'b0;
      Stp_err      <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      Par_err    <= 1'b0;
      Stp_err    <= 1'b0;

      // edge_cnt is held at 0 in IDLE so the first START cycle sees 0
      if (state == IDLE || bit_end) begin
        edge_cnt <= '0;
      end else begin
        edge_cnt <= edge_cnt + 1'b1;
      end

      case (state)
        IDLE: begin
          bit_cnt <= '0;
          if (rx_s == START_BIT) begin
            state <= START;
          end
        end

        START: begin
          if (bit_end) begin
            // Frame configuration is frozen here for the rest of the frame
            par_en_hold  <= PAR_EN;
            par_typ_hold <= PAR_TYP;
            // A start bit that votes high was a glitch: drop it silently
            state <= (sampled_bit == START_BIT) ? DATA : IDLE;
          end
        end

        DATA: begin
          if (bit_end) begin
            shift_data <= {sampled_bit, shift_data[DATA_WIDTH-1:1]};
            if (bit_cnt >= LAST_BIT) begin
              bit_cnt <= '0;
              state   <= par_en_hold ? PARITY : STOP;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end

        PARITY: begin
          if (parity_bad) begin
            par_fail <= 1'b1;
          end
          if (bit_end) begin
            state <= STOP;
          end
        end

        STOP: begin
          if (stop_bad) begin
            stp_fail <= 1'b1;
          end
          if (bit_end) begin
            data_valid <= !par_fail && !stp_final;
            if (!par_fail && !stp_final) begin
              P_DATA <= shift_data;
            end
            Par_err  <= par_fail;
            Stp_err  <= stp_final;
            par_fail <= 1'b0;
            stp_fail <= 1'b0;
            state    <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx
// Drives serial frames into uart_rx and compares every output strobe
// (cycle, data_valid, Par_err, Stp_err, P_DATA) against expectations built
// from the frame contents: a fixed vector table, hand-written corner cases
// and randomized frames scored by a behavioural frame model.
// -----------------------------------------------------------------------------
module tb_uart_rx;
  import uart_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       RX_IN = 1'b1;
  logic [5:0] Prescale = 6'd8;
  logic       PAR_EN = 1'b0;
  logic       PAR_TYP = 1'b0;
  logic [7:0] P_DATA;
  logic       data_valid;
  logic       Par_err;
  logic       Stp_err;

  always #5 clk = ~clk;

  uart_rx #(
    .DATA_WIDTH (8),
    .PRESCALE_W (6)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .RX_IN      (RX_IN),
    .Prescale   (Prescale),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .P_DATA     (P_DATA),
    .data_valid (data_valid),
    .Par_err    (Par_err),
    .Stp_err    (Stp_err)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    bit         v;
    bit         pe;
    bit         se;
    logic [7:0] d;
  } strobe_t;

  typedef struct {
    int         p;
    bit         pe;
    bit         pt;
    logic [7:0] data;
    bit         pbit;
    bit         sbit;
    int         gl;
    bit         ev;
    bit         epe;
    bit         ese;
    logic [7:0] ed;
  } vec_t;

  strobe_t got_q[$];
  strobe_t exp_q[$];

  int         n_checks = 0;
  int         n_fail = 0;
  int         last_end = -100000;  // strobe cycle of the previous frame
  int         last_d = 0;          // receiver lag behind the line for this frame
  logic [7:0] model_pdata = 8'h00;

  // Record every cycle carrying any strobe
  always @(negedge clk) begin
    if (data_valid || Par_err || Stp_err)
      got_q.push_back(strobe_t'{cyc, data_valid, Par_err, Stp_err, P_DATA});
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout, required end of test");
    $fatal(1);
  end

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1 RX_IN = 1'b1;
    end
  endtask

  // Drive one frame, one oversampling slot per clock. gl >= 0 inverts the
  // line for one cycle at a single mid-bit sample point of every data bit.
  // end_cyc is when the strobes must appear: the receiver starts 3 cycles
  // after the falling edge, or one cycle after the previous frame end if
  // that is later, and the frame lasts N*Prescale cycles.
  task automatic send_frame(input int p, input bit pe, input bit pt,
                            input logic [7:0] data, input bit pbit,
                            input bit sbit, input int gl, input bit scramble,
                            output int end_cyc);
    int n;
    int fall;
    int start;
    int b;
    bit v;
    bit bits[11];
    n = pe ? 11 : 10;
    for (int i = 0; i < 11; i++) bits[i] = 1'b1;
    bits[0] = START_BIT;
    for (int i = 0; i < 8; i++) bits[1+i] = data[i];
    if (pe) bits[9] = pbit;
    bits[n-1] = sbit;
    for (int t = 0; t < n * p; t++) begin
      @(posedge clk);
      #1;
      if (t == 0) begin
        Prescale = 6'(p);
        PAR_EN   = pe;
        PAR_TYP  = pt;
        fall     = cyc;
        start    = (fall + 3 > last_end + 1) ? fall + 3 : last_end + 1;
        last_d   = start - fall - 3;
      end
      b = t / p;
      v = bits[b];
      if (gl >= 0 && last_d == 0 && b >= 1 && b <= 8 && (t % p) == p / 2 + gl)
        v = ~v;
      RX_IN = v;
      if (scramble && t == p + p / 2) begin
        PAR_EN  = 1'($urandom);
        PAR_TYP = 1'($urandom);
      end
    end
    end_cyc  = start + n * p;
    last_end = end_cyc;
  endtask

  task automatic compare_all(input string tag);
    int n;
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s[%0d] cycle", tag, i), got_q[i].cyc, exp_q[i].cyc);
      check($sformatf("%s[%0d] data_valid", tag, i), int'(got_q[i].v), int'(exp_q[i].v));
      check($sformatf("%s[%0d] Par_err", tag, i), int'(got_q[i].pe), int'(exp_q[i].pe));
      check($sformatf("%s[%0d] Stp_err", tag, i), int'(got_q[i].se), int'(exp_q[i].se));
      check($sformatf("%s[%0d] P_DATA", tag, i), int'(got_q[i].d), int'(exp_q[i].d));
    end
    check($sformatf("%s strobe count", tag), got_q.size(), exp_q.size());
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check($sformatf("%s P_DATA", tag), int'(P_DATA), 0);
    check($sformatf("%s data_valid", tag), int'(data_valid), 0);
    check($sformatf("%s Par_err", tag), int'(Par_err), 0);
    check($sformatf("%s Stp_err", tag), int'(Stp_err), 0);
  endtask

  vec_t vecs[8];

  initial begin
    int      e;
    int      p;
    int      gap;
    bit      pe;
    bit      pt;
    bit      pbit;
    bit      sbit;
    bit      perr;
    int      gl;
    logic [7:0] data;
    strobe_t s;

    // {Prescale, PAR_EN, PAR_TYP, byte, parity bit on line, stop bit, glitch,
    //  exp data_valid, exp Par_err, exp Stp_err, exp P_DATA}
    vecs[0] = vec_t'{8,  1'b0, 1'b0, 8'hA5, 1'b0, 1'b1, -1, 1'b1, 1'b0, 1'b0, 8'hA5};
    vecs[1] = vec_t'{16, 1'b1, 1'b0, 8'h3C, 1'b0, 1'b1, -1, 1'b1, 1'b0, 1'b0, 8'h3C};
    vecs[2] = vec_t'{16, 1'b1, 1'b0, 8'h3C, 1'b1, 1'b1, -1, 1'b0, 1'b1, 1'b0, 8'h3C};
    vecs[3] = vec_t'{32, 1'b0, 1'b0, 8'h81, 1'b0, 1'b0, -1, 1'b0, 1'b0, 1'b1, 8'h3C};
    vecs[4] = vec_t'{16, 1'b0, 1'b0, 8'hF0, 1'b0, 1'b1,  1, 1'b1, 1'b0, 1'b0, 8'hF0};
    vecs[5] = vec_t'{8,  1'b1, 1'b1, 8'h00, 1'b1, 1'b1, -1, 1'b1, 1'b0, 1'b0, 8'h00};
    vecs[6] = vec_t'{32, 1'b1, 1'b1, 8'h7F, 1'b0, 1'b0, -1, 1'b0, 1'b0, 1'b1, 8'h00};
    vecs[7] = vec_t'{8,  1'b1, 1'b0, 8'h01, 1'b0, 1'b0, -1, 1'b0, 1'b1, 1'b1, 8'h00};

    // Reset state
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk);
    #1 rst = 1'b1;
    idle(10);

    // Vector table
    foreach (vecs[i]) begin
      send_frame(vecs[i].p, vecs[i].pe, vecs[i].pt, vecs[i].data, vecs[i].pbit,
                 vecs[i].sbit, vecs[i].gl, 1'b0, e);
      idle(20);
      exp_q.push_back(strobe_t'{e, vecs[i].ev, vecs[i].epe, vecs[i].ese, vecs[i].ed});
      $display("vec %0d: P=%0d par_en=%0d byte=%h stop=%0d -> expect valid=%0d perr=%0d serr=%0d at cycle %0d",
               i, vecs[i].p, vecs[i].pe, vecs[i].data, vecs[i].sbit,
               vecs[i].ev, vecs[i].epe, vecs[i].ese, e);
    end
    compare_all("table");
    model_pdata = 8'h00;

    // Start-bit glitch: 3 low cycles must be dropped, then a clean 0x55
    @(posedge clk);
    #1 Prescale = 6'd16;
    repeat (3) begin
      @(posedge clk);
      #1 RX_IN = 1'b0;
    end
    idle(60);
    compare_all("glitch");
    send_frame(16, 1'b0, 1'b0, 8'h55, 1'b0, 1'b1, -1, 1'b0, e);
    idle(20);
    exp_q.push_back(strobe_t'{e, 1'b1, 1'b0, 1'b0, 8'h55});
    model_pdata = 8'h55;
    $display("glitch then byte 55: expect valid at cycle %0d", e);
    compare_all("after_glitch");

    // Randomized frames against the frame model
    p = PRESCALE_16;
    for (int k = 0; k < 24; k++) begin
      gap = (last_d == 0 && $urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 10);
      if (gap > 0) idle(gap);
      if (gap >= 6) begin
        case ($urandom_range(0, 2))
          0:       p = PRESCALE_8;
          1:       p = PRESCALE_16;
          default: p = PRESCALE_32;
        endcase
      end
      data = 8'($urandom);
      pe   = 1'($urandom);
      pt   = 1'($urandom);
      pbit = ((^data) ^ pt) ^ ($urandom_range(0, 3) == 0);
      sbit = ($urandom_range(0, 4) != 0);
      gl   = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 2)) : -1;
      send_frame(p, pe, pt, data, pbit, sbit, gl, 1'b1, e);
      perr = pe && (pbit != ((^data) ^ pt));
      s.cyc = e;
      s.pe  = perr;
      s.se  = !sbit;
      s.v   = !perr && sbit;
      if (s.v) model_pdata = data;
      s.d = model_pdata;
      exp_q.push_back(s);
      $display("rand %0d: P=%0d gap=%0d par_en=%0d typ=%0d byte=%h pbit=%0d stop=%0d glitch=%0d -> expect valid=%0d perr=%0d serr=%0d",
               k, p, gap, pe, pt, data, pbit, sbit, gl, s.v, s.pe, s.se);
    end
    idle(40);
    compare_all("random");

    // Back-to-back 0x12, 0x34, then reset in the middle of a third frame
    idle(10);
    send_frame(16, 1'b0, 1'b0, 8'h12, 1'b0, 1'b1, -1, 1'b0, e);
    exp_q.push_back(strobe_t'{e, 1'b1, 1'b0, 1'b0, 8'h12});
    send_frame(16, 1'b0, 1'b0, 8'h34, 1'b0, 1'b1, -1, 1'b0, e);
    exp_q.push_back(strobe_t'{e, 1'b1, 1'b0, 1'b0, 8'h34});
    $display("back-to-back 12, 34: expect second valid at cycle %0d", e);
    repeat (16) begin
      @(posedge clk);
      #1 RX_IN = 1'b0;
    end
    idle(30);
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("mid_frame_reset");
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    last_end = -100000;
    last_d = 0;
    idle(400);
    check_reset_outputs("after_reset");
    compare_all("b2b_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
